// File: rtl/key_sched_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 key schedule.
// KEY_SCHED_ZEROIZE_EN is consumed by the modules that import this.
package key_sched_pkg;
  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int NUM_KEYS   = 11;
  localparam int RK_ADDR_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } ks_state_e;

  typedef logic [KEY_W-1:0] rkey_t;
  typedef rkey_t rkey_arr_t [NUM_KEYS];

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254, then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gmul(x, x);
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      r  = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(
    input logic [RK_ADDR_W-1:0] r
  );
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Control/read bundle of the AES-128 key-schedule sequencer.
// KEY_SCHED_ZEROIZE_EN adds the zeroize request.
interface aes_key_schedule_seq_if;
  import key_sched_pkg::*;

  logic                 start;
  rkey_t                key_in;
  logic                 busy;
  logic                 done;
  logic                 keys_valid;
  logic [RK_ADDR_W-1:0] rd_addr;
  rkey_t                rd_key;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic                 zeroize;

  modport master (
    output start, key_in, rd_addr, zeroize,
    input  busy, done, keys_valid, rd_key
  );
  modport slave (
    input  start, key_in, rd_addr, zeroize,
    output busy, done, keys_valid, rd_key
  );
`else
  modport master (
    output start, key_in, rd_addr,
    input  busy, done, keys_valid, rd_key
  );
  modport slave (
    input  start, key_in, rd_addr,
    output busy, done, keys_valid, rd_key
  );
`endif
endinterface

// File: rtl/GENERATE_KEY.sv
// Single-round AES-128 key expander with SBOX_LAT registered
// S-box stages on the RotWord/SubWord path.
module GENERATE_KEY
  import key_sched_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  rkey_t                IN_KEY,
  input  logic [RK_ADDR_W-1:0] ROUND_KEY,
  output rkey_t                OUT_KEY
);
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] t;
  logic [31:0] o0, o1, o2, o3;
  logic [31:0] pipe [SBOX_LAT];

  assign rot = {IN_KEY[23:0], IN_KEY[31:24]};

  always_comb begin
    sub = '0;
    for (int b = 0; b < 4; b++)
      sub[8*b +: 8] = sbox(rot[8*b +: 8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SBOX_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= sub;
      for (int i = 1; i < SBOX_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign t  = pipe[SBOX_LAT-1] ^ {rcon(ROUND_KEY), 24'h0};
  assign o0 = IN_KEY[127:96] ^ t;
  assign o1 = IN_KEY[95:64]  ^ o0;
  assign o2 = IN_KEY[63:32]  ^ o1;
  assign o3 = IN_KEY[31:0]   ^ o2;
  assign OUT_KEY = {o0, o1, o2, o3};
endmodule

// File: rtl/key_store_rf.sv
// 11x128 round-key register file, registered read port.
// KEY_SCHED_ZEROIZE_EN adds a synchronous wipe.
module key_store_rf
  import key_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                 zeroize,
`endif
  input  logic                 we,
  input  logic [RK_ADDR_W-1:0] waddr,
  input  rkey_t                wdata,
  input  logic [RK_ADDR_W-1:0] raddr,
  output rkey_t                rdata
);
  localparam logic [RK_ADDR_W-1:0] LAST =
    RK_ADDR_W'(NUM_KEYS - 1);

  rkey_arr_t mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++)
        mem[i] <= '0;
      rdata <= '0;
`ifdef KEY_SCHED_ZEROIZE_EN
    end else if (zeroize) begin
      for (int i = 0; i < NUM_KEYS; i++)
        mem[i] <= '0;
      rdata <= '0;
`endif
    end else begin
      rdata <= (raddr <= LAST) ? mem[raddr] : '0;
      if (we && waddr <= LAST)
        mem[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/aes_key_schedule_seq.sv
// AES-128 key-schedule sequencer: runs GENERATE_KEY 10 times into
// key_store_rf. KEY_SCHED_ZEROIZE_EN enables the zeroize abort.
module aes_key_schedule_seq
  import key_sched_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_key_schedule_seq_if.slave bus
);
  localparam logic [1:0] WLAST = 2'(SBOX_LAT - 1);
  localparam logic [RK_ADDR_W-1:0] RLAST =
    RK_ADDR_W'(NUM_ROUNDS - 1);

  ks_state_e            state, state_d;
  logic [RK_ADDR_W-1:0] round, round_d;
  logic [1:0]           wcnt, wcnt_d;
  rkey_t                work_key, work_key_d;
  logic                 busy, busy_d;
  logic                 done, done_d;
  logic                 kv, kv_d;
  logic                 we;
  logic [RK_ADDR_W-1:0] waddr;
  rkey_t                wdata;
  rkey_t                out_key;

  GENERATE_KEY #(.SBOX_LAT(SBOX_LAT)) u_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .IN_KEY    (work_key),
    .ROUND_KEY (round),
    .OUT_KEY   (out_key)
  );

  key_store_rf u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize (bus.zeroize),
`endif
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (bus.rd_addr),
    .rdata   (bus.rd_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      round    <= '0;
      wcnt     <= '0;
      work_key <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      kv       <= 1'b0;
    end else begin
      state    <= state_d;
      round    <= round_d;
      wcnt     <= wcnt_d;
      work_key <= work_key_d;
      busy     <= busy_d;
      done     <= done_d;
      kv       <= kv_d;
    end
  end

  always_comb begin
    state_d    = state;
    round_d    = round;
    wcnt_d     = wcnt;
    work_key_d = work_key;
    busy_d     = busy;
    done_d     = 1'b0;
    kv_d       = kv;
    we         = 1'b0;
    waddr      = round + 4'd1;
    wdata      = out_key;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          we         = 1'b1;
          waddr      = '0;
          wdata      = bus.key_in;
          work_key_d = bus.key_in;
          round_d    = '0;
          wcnt_d     = '0;
          kv_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == WLAST) begin
          wcnt_d  = '0;
          state_d = CAPTURE;
        end else begin
          wcnt_d = wcnt + 2'd1;
        end
      end
      CAPTURE: begin
        we         = 1'b1;
        work_key_d = out_key;
        if (round == RLAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = IDLE;
        end else begin
          round_d = round + 4'd1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef KEY_SCHED_ZEROIZE_EN
    // Abort wins over start and over the final capture.
    if (bus.zeroize) begin
      state_d    = IDLE;
      round_d    = '0;
      wcnt_d     = '0;
      work_key_d = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      kv_d       = 1'b0;
      we         = 1'b0;
    end
`endif
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.keys_valid = kv;
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq (SBOX_LAT=1),
// FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule_seq;
  import key_sched_pkg::*;

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KB  = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_seq_if bus();

  aes_key_schedule_seq #(.SBOX_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [127:0] exp;
  } rexp_t;

  typedef struct {
    string        name;
    logic [127:0] act;
    logic [127:0] exp;
  } sexp_t;

  rexp_t rq[$];
  sexp_t sq[$];
  int    dq[$];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic rd_req = 1'b0;
  logic rd_req_q = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_req_q <= rd_req;
  end

  always @(negedge clk) begin
    rexp_t r;
    sexp_t s;
    int    e;
    if (bus.done) begin
      n_cmp++;
      if (dq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done cyc=%0d got 1 required 0", cyc);
      end else begin
        e = dq.pop_front();
        if (cyc != e) begin
          n_bad++;
          $display("FAIL done_cycle got %0d required %0d", cyc, e);
        end
      end
    end
    if (rd_req_q) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_bad++;
        $display("FAIL rd_underflow got %h required none", bus.rd_key);
      end else begin
        r = rq.pop_front();
        if (bus.rd_key !== r.exp) begin
          n_bad++;
          $display("FAIL %s got %h required %h", r.name, bus.rd_key, r.exp);
        end
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      n_cmp++;
      if (s.act !== s.exp) begin
        n_bad++;
        $display("FAIL %s got %0h required %0h", s.name, s.act, s.exp);
      end
    end
  end

  task automatic st(input string n, input logic [127:0] a,
                    input logic [127:0] e);
    sq.push_back('{n, a, e});
  endtask

  task automatic rd_issue(input logic [3:0] a, input logic [127:0] e,
                          input string n);
    bus.rd_addr = a;
    rd_req = 1'b1;
    rq.push_back('{n, e});
  endtask

  task automatic rd(input logic [3:0] a, input logic [127:0] e,
                    input string n);
    rd_issue(a, e, n);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // Called at a negedge; the next posedge is E0.
  task automatic go(input logic [127:0] k, input bit exp_done);
    bus.key_in = k;
    bus.start  = 1'b1;
    if (exp_done) dq.push_back(cyc + 21);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int kvc;
    bus.start   = 1'b0;
    bus.key_in  = '0;
    bus.rd_addr = '0;
`ifdef KEY_SCHED_ZEROIZE_EN
    bus.zeroize = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    st("rst_busy", 128'(bus.busy), 0);
    st("rst_done", 128'(bus.done), 0);
    st("rst_kv", 128'(bus.keys_valid), 0);
    st("rst_rd_key", bus.rd_key, 0);
    for (int a = 0; a < 16; a++) rd(4'(a), '0, "rst_rd");

    // FIPS-197 vector
    go(K0, 1'b1);
    repeat (19) @(negedge clk);
    st("run_busy", 128'(bus.busy), 1);
    st("run_kv", 128'(bus.keys_valid), 0);
    @(negedge clk);
    st("end_busy", 128'(bus.busy), 0);
    st("end_kv", 128'(bus.keys_valid), 1);
    @(negedge clk);
    st("done_width", 128'(bus.done), 0);
    rd(4'd1, K1, "fips_rk1");
    rd(4'd2, K2, "fips_rk2");
    rd(4'd10, K10, "fips_rk10");
    rd(4'd0, K0, "fips_rk0");

    // start while busy is ignored
    go(K0, 1'b1);
    repeat (4) @(negedge clk);
    bus.key_in = KB;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    st("ign_kv", 128'(bus.keys_valid), 1);
    rd(4'd1, K1, "ign_rk1");
    rd(4'd10, K10, "ign_rk10");
    rd(4'd0, K0, "ign_rk0");

    // reset mid-run
    go(K0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    st("mid_rst_kv", 128'(bus.keys_valid), 0);
    st("mid_rst_busy", 128'(bus.busy), 0);
    st("mid_rst_done", 128'(bus.done), 0);
    rd(4'd1, '0, "in_rst_rd");
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'd0, '0, "post_rst_rk0");
    rd(4'd1, '0, "post_rst_rk1");
    rd(4'd10, '0, "post_rst_rk10");
    go(K0, 1'b1);
    repeat (20) @(negedge clk);
    rd(4'd10, K10, "rerun_rk10");
    rd(4'd1, K1, "rerun_rk1");

    // back-to-back with start held high
    bus.key_in = K0;
    bus.start  = 1'b1;
    dq.push_back(cyc + 21);
    dq.push_back(cyc + 42);
    kvc = 0;
    rd_issue(4'd11, '0, "b2b_rd11");
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 0) bus.key_in = '0;
      if (i == 21) bus.start = 1'b0;
      if (i >= 1 && i <= 40 && bus.keys_valid) kvc++;
      if (i == 20) begin
        st("b2b_gap_busy", 128'(bus.busy), 0);
        st("b2b_gap_kv", 128'(bus.keys_valid), 1);
      end
      if (i == 21) begin
        st("b2b_restart_busy", 128'(bus.busy), 1);
        st("b2b_restart_kv", 128'(bus.keys_valid), 0);
      end
      rd_issue(4'd11, '0, "b2b_rd11");
    end
    @(negedge clk);
    rd_req = 1'b0;
    st("b2b_kv_cycles", 128'(kvc), 1);
    rd(4'd1, Z1, "zero_rk1");
    rd(4'd10, Z10, "zero_rk10");
    rd(4'd0, '0, "zero_rk0");

`ifdef KEY_SCHED_ZEROIZE_EN
    go(K0, 1'b0);
    repeat (12) @(negedge clk);
    bus.zeroize = 1'b1;
    @(negedge clk);
    bus.zeroize = 1'b0;
    st("zz_busy", 128'(bus.busy), 0);
    st("zz_kv", 128'(bus.keys_valid), 0);
    repeat (25) @(negedge clk);
    for (int a = 0; a < 11; a++) rd(4'(a), '0, "zz_entry");
    go(K0, 1'b1);
    repeat (20) @(negedge clk);
    rd(4'd10, K10, "zz_rerun_rk10");
`endif

    repeat (2) @(negedge clk);
    st("missed_done", 128'(dq.size()), 0);
    st("rd_pending", 128'(rq.size()), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
